// File: rtl/axilite_arbiter_pkg.sv
// Shared state encoding, response codes and default widths for the
// two-requester AXI-Lite arbiter.
package axilite_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves to
// the currently granted requester when advance is pulsed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // r_last = index of the requester served most recently
  logic r_last;

  // Grant selection: contention goes to the requester not served last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update; reset value gives requester 0 priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      r_last <= gnt[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/axilite_arbiter.sv
// Two-requester AXI-Lite master: round-robin grant, one transaction in flight,
// registered channel handshakes and a one-cycle completion pulse per request.
module axilite_arbiter
  import axilite_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic [1:0]                rq_valid,
  input  logic [1:0]                rq_write,
  input  logic [2*ADDR_WIDTH-1:0]   rq_addr,
  input  logic [2*DATA_WIDTH-1:0]   rq_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] rq_wstrb,
  output logic [1:0]                rq_done,
  output logic [DATA_WIDTH-1:0]     rq_rdata,
  output logic [1:0]                rq_resp,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                r_state;
  logic [1:0]            r_grant;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [1:0]            r_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  logic [1:0]            w_arb_req;
  logic [1:0]            w_gnt;
  logic                  w_advance;
  logic                  w_sel;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_WIDTH-1:0] w_sel_wstrb;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_complete;

  // In DONE the arbiter sees only the owner so the pointer lands on it,
  // regardless of what the other requester is doing that cycle.
  assign w_arb_req = (r_state == ST_DONE) ? r_grant : rq_valid;
  assign w_advance = (r_state == ST_DONE);

  rr_arbiter2 u_rr (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .req     (w_arb_req),
    .advance (w_advance),
    .gnt     (w_gnt)
  );

  assign w_sel       = w_gnt[1];
  assign w_sel_write = w_sel ? rq_write[1] : rq_write[0];
  assign w_sel_addr  = w_sel ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rq_addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata = w_sel ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : rq_wdata[DATA_WIDTH-1:0];
  assign w_sel_wstrb = w_sel ? rq_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : rq_wstrb[STRB_WIDTH-1:0];

  assign w_aw_done  = !r_awvalid || m_axi_awready;
  assign w_w_done   = !r_wvalid || m_axi_wready;
  assign w_complete = ((r_state == ST_WRESP) && r_bready && m_axi_bvalid) ||
                      ((r_state == ST_RDATA) && r_rready && m_axi_rvalid);

  // Transaction sequencer, channel handshakes and requester return path
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done    <= 2'b00;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_grant <= w_gnt;
            r_write <= w_sel_write;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wstrb <= w_sel_wstrb;
            if (w_sel_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD;
            end
          end
        end
        ST_WR: begin
          // AW and W retire independently; leave only once both are accepted
          if (r_awvalid && m_axi_awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && m_axi_wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (r_bready && m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_RD: begin
          if (r_arvalid && m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_rready && m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
      if (w_complete) begin
        r_done  <= r_grant;
        r_rdata <= r_write ? '0 : m_axi_rdata;
        r_resp  <= r_write ? m_axi_bresp : m_axi_rresp;
      end
    end
  end

  assign rq_done       = r_done;
  assign rq_rdata      = r_rdata;
  assign rq_resp       = r_resp;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axilite_arbiter.sv
// Scoreboard bench for axilite_arbiter with a small AXI-Lite slave model
// whose per-channel handshake delays are adjustable at run time.
module tb_axilite_arbiter;
  import axilite_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      rq_valid, rq_write, rq_done, rq_resp;
  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [2*SW-1:0] rq_wstrb;
  logic [DW-1:0]   rq_rdata;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp, rresp;

  axilite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr),
    .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
    .rq_done(rq_done), .rq_rdata(rq_rdata), .rq_resp(rq_resp),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_bresp(bresp), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_araddr(araddr), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave model: 16 words at 0x00..0x3C, SLVERR above
  logic [31:0] mem [0:15];
  int aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  int aw_wait, w_wait, b_wait, r_wait;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
  logic have_aw, have_w, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      have_aw <= 1'b0; have_w <= 1'b0; r_pend <= 1'b0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0;
    end else begin
      if (awready) awready <= 1'b0;
      else if (awvalid) begin
        if (aw_wait >= aw_delay) begin awready <= 1'b1; aw_wait <= 0; end
        else aw_wait <= aw_wait + 1;
      end
      if (awvalid && awready) begin have_aw <= 1'b1; s_awaddr <= awaddr; n_aw <= n_aw + 1; end
      if (wready) wready <= 1'b0;
      else if (wvalid) begin
        if (w_wait >= w_delay) begin wready <= 1'b1; w_wait <= 0; end
        else w_wait <= w_wait + 1;
      end
      if (wvalid && wready) begin have_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; n_w <= n_w + 1; end
      if (have_aw && have_w && !bvalid) begin
        if (b_wait >= b_delay) begin
          b_wait <= 0; bvalid <= 1'b1; have_aw <= 1'b0; have_w <= 1'b0;
          if (s_awaddr < 32'h40) begin
            bresp <= 2'b00;
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
          end else bresp <= 2'b10;
        end else b_wait <= b_wait + 1;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
      if (arready) arready <= 1'b0;
      else if (arvalid) arready <= 1'b1;
      if (arvalid && arready) begin r_pend <= 1'b1; s_araddr <= araddr; n_ar <= n_ar + 1; end
      if (r_pend && !rvalid) begin
        if (r_wait >= r_delay) begin
          r_wait <= 0; r_pend <= 1'b0; rvalid <= 1'b1;
          rdata <= (s_araddr < 32'h40) ? mem[s_araddr[5:2]] : 32'h0;
          rresp <= (s_araddr < 32'h40) ? 2'b00 : 2'b10;
        end else r_wait <= r_wait + 1;
      end
      if (rvalid && rready) begin rvalid <= 1'b0; n_r <= n_r + 1; end
    end
  end

  // ---------------- scoreboard and monitor
  typedef struct packed {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];
  int n_done = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rq_done != 2'b00) begin
      n_done++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=%b required=none", rq_done);
      end else begin
        e = exp_q.pop_front();
        chk("done_owner", {30'h0, rq_done}, {30'h0, e.done});
        chk("rq_rdata", rq_rdata, e.rdata);
        chk("rq_resp", {30'h0, rq_resp}, {30'h0, e.resp});
      end
    end
  end

  // ---------------- requester helpers
  task automatic push_exp(input int i, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.done = (i == 0) ? 2'b01 : 2'b10;
    e.rdata = d;
    e.resp = r;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    rq_write[i] = wr;
    rq_addr[i*AW +: AW] = a;
    rq_wdata[i*DW +: DW] = d;
    rq_wstrb[i*SW +: SW] = s;
    rq_valid[i] = 1'b1;
  endtask

  task automatic wait_done(input logic [1:0] mask, input string name);
    logic [1:0] seen;
    int cyc;
    seen = 2'b00;
    cyc = 0;
    while (seen != mask && cyc < 300) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++)
        if (mask[i] && rq_done[i]) begin seen[i] = 1'b1; rq_valid[i] = 1'b0; end
    end
    if (seen != mask) begin
      checks++; failures++;
      rq_valid = 2'b00;
      $display("FAIL timeout_%s actual=%b required=%b", name, seen, mask);
    end
  endtask

  task automatic txn(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_d, input logic [1:0] exp_r);
    push_exp(i, exp_d, exp_r);
    set_req(i, wr, a, d, s);
    wait_done((i == 0) ? 2'b01 : 2'b10, "txn");
  endtask

  task automatic pair(input logic wr, input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [31:0] e0, input logic [31:0] e1);
    push_exp(0, e0, RESP_OKAY);
    push_exp(1, e1, RESP_OKAY);
    set_req(0, wr, a0, d0, 4'hF);
    set_req(1, wr, a1, d1, 4'hF);
    wait_done(2'b11, "pair");
  endtask

  initial begin
    int a0, w0, b0, ar0, r0, d0, cyc;
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    rq_valid = 2'b00; rq_write = 2'b00; rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst_done", {30'h0, rq_done}, 32'h0);
    chk("rst_rdata", rq_rdata, 32'h0);
    chk("rst_resp", {30'h0, rq_resp}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // full-word write then readback, both from requester 0
    txn(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 32'h0, RESP_OKAY);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hAABBCCDD, RESP_OKAY);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rq_rdata, 32'hAABBCCDD);

    // byte-strobed write merges into the existing word
    txn(0, 1'b1, 32'h4, 32'hAAAAAA11, 4'h1, 32'h0, RESP_OKAY);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hAABBCC11, RESP_OKAY);
    // requester 1 read leaves the pointer on r1, so r0 wins the next contention
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hAABBCC11, RESP_OKAY);

    pair(1'b1, 32'h8, 32'h1000, 32'hC, 32'h1001, 32'h0, 32'h0);
    pair(1'b0, 32'h8, 32'h0, 32'hC, 32'h0, 32'h1000, 32'h1001);
    for (int k = 0; k < 10; k++)
      pair(1'b1, 32'h10, 32'h2000 + k, 32'h14, 32'h3000 + k, 32'h0, 32'h0);
    pair(1'b0, 32'h10, 32'h0, 32'h14, 32'h0, 32'h2009, 32'h3009);

    // out-of-range and misaligned addresses pass through untouched
    txn(1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, RESP_SLVERR);
    txn(0, 1'b1, 32'h100, 32'h55, 4'hF, 32'h0, RESP_SLVERR);
    txn(1, 1'b0, 32'h6, 32'h0, 4'h0, 32'hAABBCC11, RESP_OKAY);
    chk("araddr_passthru", s_araddr, 32'h6);

    // staggered AW/W readiness and a slow read response
    a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; d0 = n_done;
    aw_delay = 0; w_delay = 3; r_delay = 5;
    txn(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, RESP_OKAY);
    aw_delay = 4; w_delay = 0;
    txn(1, 1'b1, 32'h24, 32'h9ABCDEF0, 4'hF, 32'h0, RESP_OKAY);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, RESP_OKAY);
    chk("aw_handshakes", n_aw - a0, 32'd2);
    chk("w_handshakes", n_w - w0, 32'd2);
    chk("b_handshakes", n_b - b0, 32'd2);
    chk("ar_handshakes", n_ar - ar0, 32'd1);
    chk("r_handshakes", n_r - r0, 32'd1);
    chk("done_pulses", n_done - d0, 32'd3);
    aw_delay = 0; w_delay = 0; r_delay = 0;

    // reset while waiting for the write response abandons the transaction
    b_delay = 12;
    set_req(0, 1'b1, 32'h28, 32'hDEAD0000, 4'hF);
    cyc = 0;
    while (!bready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("reached_wresp", {31'h0, bready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("midrst_done", {30'h0, rq_done}, 32'h0);
    rq_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    b_delay = 0;
    repeat (15) @(negedge clk);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hAABBCC11, RESP_OKAY);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
